// File: rtl/flac_enc_pkg.sv
// Shared constants, FSM state type and Rice folding helper for the FLAC fixed subframe encoder.
package flac_enc_pkg;

  localparam int unsigned RES_W        = 21;
  localparam int unsigned PACK_W       = 64;
  localparam int unsigned CODEWORD_MAX = 37;

  localparam logic [2:0] SUBFRAME_FIXED = 3'b001;
  localparam logic [1:0] CODING_RICE    = 2'b00;
  localparam logic [3:0] PART_ORDER     = 4'b0000;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StWarmup,
    StResHdr,
    StResidual,
    StFlush,
    StDone
  } enc_state_e;

  // Zig-zag fold: 0,-1,1,-2,2 -> 0,1,2,3,4
  function automatic logic [RES_W-1:0] rice_fold(input logic signed [RES_W-1:0] r);
    return (r << 1) ^ {RES_W{r[RES_W-1]}};
  endfunction

endpackage

// File: rtl/bit_packer.sv
// MSB-first bit accumulator: takes one field of up to 32 bits per cycle and emits 16-bit words.
module bit_packer
  import flac_enc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       value,
  input  logic [5:0]        len,
  input  logic              push,
  input  logic              flush,
  output logic [15:0]       word,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              has_room,
  output logic              empty
);

  logic [PACK_W-1:0] acc_q, acc_d, base;
  logic [6:0]        cnt_q, cnt_d, base_cnt;
  logic [15:0]       word_q;
  logic              we_q, shift;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       mask;

  always_comb begin
    shift    = (cnt_q >= 7'd16) || (flush && (cnt_q != 7'd0));
    base     = shift ? (acc_q << 16) : acc_q;
    base_cnt = (cnt_q >= 7'd16) ? (cnt_q - 7'd16) : (shift ? 7'd0 : cnt_q);
    mask     = 32'((33'd1 << len) - 33'd1);
    acc_d    = base;
    cnt_d    = base_cnt;
    if (push) begin
      // Left-align the new field right below the bits already held
      acc_d = base | ({32'd0, value & mask} << (7'd64 - base_cnt - 7'(len)));
      cnt_d = base_cnt + 7'(len);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      we_q   <= 1'b0;
      addr_q <= ADDR_W'(BASE_ADDR);
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      we_q  <= shift;
      if (shift) word_q <= acc_q[PACK_W-1 -: 16];
      if (start) addr_q <= ADDR_W'(BASE_ADDR);
      else if (we_q) addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign word     = word_q;
  assign we       = we_q;
  assign addr     = addr_q;
  assign has_room = cnt_q <= 7'(PACK_W - CODEWORD_MAX);
  assign empty    = cnt_q == 7'd0;

endmodule

// File: rtl/fixed_subframe_encoder.sv
// FLAC fixed-predictor subframe encoder (order 0..4, single-partition Rice) writing 16-bit words.
// Optional ENC_WORD_COUNT_EN adds oWordCount, the number of words written in the frame.
module fixed_subframe_encoder
  import flac_enc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic [15:0]        iBlockSize,
  input  logic [2:0]         iOrder,
  input  logic [3:0]         iRiceParam,
  input  logic signed [15:0] iSample,
  input  logic               iSampleValid,
  output logic               oReady,
  output logic [ADDR_W-1:0]  oWriteAddr,
  output logic [15:0]        oData,
  output logic               oWriteEnable,
  output logic               oFrameDone
`ifdef ENC_WORD_COUNT_EN
  ,
  output logic [15:0]        oWordCount
`endif
);

  enc_state_e state_q, state_d;
  logic [2:0]  order_q, order_in;
  logic [3:0]  k_q, k_in;
  logic [15:0] bs_q, idx_q, idx_d;
  logic signed [15:0] x1_q, x2_q, x3_q, x4_q;
  logic        busy_q, busy_d;
  logic [RES_W-1:0] q_rem_q, q_rem_d, u_q, u_d;

  logic        push, flush, start, has_room, empty, ready, accept;
  logic [31:0] pk_value, tail_value;
  logic [5:0]  pk_len, tail_len;
  logic signed [RES_W-1:0] s0, s1, s2, s3, s4, pred, res;
  logic [RES_W-1:0] u_new, q_new, tail_q, tail_u;

  assign order_in = (iOrder > 3'd4) ? 3'd4 : iOrder;
  assign k_in     = (iRiceParam == 4'd15) ? 4'd14 : iRiceParam;

  always_comb begin
    s0 = RES_W'(iSample);
    s1 = RES_W'(x1_q);
    s2 = RES_W'(x2_q);
    s3 = RES_W'(x3_q);
    s4 = RES_W'(x4_q);
    unique case (order_q)
      3'd0:    pred = '0;
      3'd1:    pred = s1;
      3'd2:    pred = (s1 <<< 1) - s2;
      3'd3:    pred = (s1 <<< 1) + s1 - (s2 <<< 1) - s2 + s3;
      default: pred = (s1 <<< 2) - (s2 <<< 2) - (s2 <<< 1) + (s3 <<< 2) - s4;
    endcase
    res   = s0 - pred;
    u_new = rice_fold(res);
    q_new = u_new >> k_q;
    // Terminating field: remaining (<16) zeros are implied by the length, then '1' and k bits
    tail_q     = busy_q ? q_rem_q : q_new;
    tail_u     = busy_q ? u_q : u_new;
    tail_value = (32'd1 << k_q) | (32'(tail_u) & ((32'd1 << k_q) - 32'd1));
    tail_len   = 6'(tail_q[3:0]) + 6'd1 + 6'(k_q);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    q_rem_d  = q_rem_q;
    u_d      = u_q;
    push     = 1'b0;
    flush    = 1'b0;
    start    = 1'b0;
    ready    = 1'b0;
    accept   = 1'b0;
    pk_value = '0;
    pk_len   = '0;
    unique case (state_q)
      StIdle: begin
        if (iEnable) begin
          start   = 1'b1;
          idx_d   = '0;
          busy_d  = 1'b0;
          state_d = StHeader;
        end
      end
      StHeader: begin
        if (has_room) begin
          push     = 1'b1;
          pk_value = {24'd0, 1'b0, SUBFRAME_FIXED, order_q, 1'b0};
          pk_len   = 6'd8;
          state_d  = (order_q == 3'd0) ? StResHdr : StWarmup;
        end
      end
      StWarmup: begin
        ready = has_room;
        if (ready && iSampleValid) begin
          accept   = 1'b1;
          push     = 1'b1;
          pk_value = {16'd0, iSample};
          pk_len   = 6'd16;
          idx_d    = idx_q + 16'd1;
          if (idx_d == {13'd0, order_q}) state_d = StResHdr;
        end
      end
      StResHdr: begin
        if (has_room) begin
          push     = 1'b1;
          pk_value = {22'd0, CODING_RICE, PART_ORDER, k_q};
          pk_len   = 6'd10;
          state_d  = StResidual;
        end
      end
      StResidual: begin
        if (busy_q) begin
          if (has_room) begin
            push = 1'b1;
            if (q_rem_q >= RES_W'(16)) begin
              pk_len  = 6'd16;
              q_rem_d = q_rem_q - RES_W'(16);
            end else begin
              pk_value = tail_value;
              pk_len   = tail_len;
              busy_d   = 1'b0;
              if (idx_q == bs_q) state_d = StFlush;
            end
          end
        end else begin
          ready = has_room;
          if (ready && iSampleValid) begin
            accept = 1'b1;
            push   = 1'b1;
            idx_d  = idx_q + 16'd1;
            if (q_new >= RES_W'(16)) begin
              // Long unary run: first 16 zeros now, the rest over the following cycles
              pk_len  = 6'd16;
              busy_d  = 1'b1;
              q_rem_d = q_new - RES_W'(16);
              u_d     = u_new;
            end else begin
              pk_value = tail_value;
              pk_len   = tail_len;
              if (idx_d == bs_q) state_d = StFlush;
            end
          end
        end
      end
      StFlush: begin
        if (empty) state_d = StDone;
        else flush = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= StIdle;
      order_q <= '0;
      k_q     <= '0;
      bs_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      q_rem_q <= '0;
      u_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      x4_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      q_rem_q <= q_rem_d;
      u_q     <= u_d;
      if (start) begin
        order_q <= order_in;
        k_q     <= k_in;
        bs_q    <= iBlockSize;
      end
      if (accept) begin
        x4_q <= x3_q;
        x3_q <= x2_q;
        x2_q <= x1_q;
        x1_q <= iSample;
      end
    end
  end

  bit_packer #(
    .BASE_ADDR(BASE_ADDR),
    .ADDR_W   (ADDR_W)
  ) u_packer (
    .clk     (iClock),
    .rst     (iReset),
    .start   (start),
    .value   (pk_value),
    .len     (pk_len),
    .push    (push),
    .flush   (flush),
    .word    (oData),
    .we      (oWriteEnable),
    .addr    (oWriteAddr),
    .has_room(has_room),
    .empty   (empty)
  );

  assign oReady     = ready;
  assign oFrameDone = state_q == StDone;

`ifdef ENC_WORD_COUNT_EN
  logic [15:0] wc_q;
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) wc_q <= '0;
    else if (start) wc_q <= '0;
    else if (oWriteEnable) wc_q <= wc_q + 16'd1;
  end
  assign oWordCount = wc_q;
`endif

endmodule

// File: tb/tb_fixed_subframe_encoder.sv
// Bench for fixed_subframe_encoder: bit-level reference encoder plus a decoder loop-back model.
module tb_fixed_subframe_encoder;

  localparam logic [15:0] BASE = 16'd0;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic [15:0]        iBlockSize;
  logic [2:0]         iOrder;
  logic [3:0]         iRiceParam;
  logic signed [15:0] iSample;
  logic               iSampleValid;
  logic               oReady;
  logic [15:0]        oWriteAddr;
  logic [15:0]        oData;
  logic               oWriteEnable;
  logic               oFrameDone;
`ifdef ENC_WORD_COUNT_EN
  logic [15:0]        oWordCount;
`endif

  always #5 iClock = ~iClock;

  fixed_subframe_encoder #(
    .BASE_ADDR(BASE),
    .ADDR_W   (16)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iEnable     (iEnable),
    .iBlockSize  (iBlockSize),
    .iOrder      (iOrder),
    .iRiceParam  (iRiceParam),
    .iSample     (iSample),
    .iSampleValid(iSampleValid),
    .oReady      (oReady),
    .oWriteAddr  (oWriteAddr),
    .oData       (oData),
    .oWriteEnable(oWriteEnable),
    .oFrameDone  (oFrameDone)
`ifdef ENC_WORD_COUNT_EN
    ,
    .oWordCount  (oWordCount)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          smp[$];
  bit          exp_bits[$];
  logic [15:0] exp_words[$];
  logic [15:0] got_words[$];
  logic [15:0] got_addrs[$];
  int          done_cnt;
  int          dec[$];
  bit          dbits[$];
  int          dpos;

  always @(negedge iClock) begin
    if (oWriteEnable) begin
      got_words.push_back(oData);
      got_addrs.push_back(oWriteAddr);
    end
    if (oFrameDone) done_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic void put_bits(input logic [31:0] v, input int n);
    for (int j = n - 1; j >= 0; j--) exp_bits.push_back(v[j]);
  endfunction

  // Reference encoder straight from the subframe format rules.
  function automatic void model_encode(input int order_in, input int k_in, input int bs);
    int order, k, p, r, u, q;
    logic [15:0] w;
    order = (order_in > 4) ? 4 : order_in;
    k     = (k_in == 15) ? 14 : k_in;
    exp_bits.delete();
    exp_words.delete();
    put_bits(32'h10 | (order << 1), 8);
    for (int i = 0; i < order; i++) put_bits(smp[i] & 32'hFFFF, 16);
    put_bits(k, 10);
    for (int i = order; i < bs; i++) begin
      case (order)
        0:       p = 0;
        1:       p = smp[i-1];
        2:       p = 2 * smp[i-1] - smp[i-2];
        3:       p = 3 * smp[i-1] - 3 * smp[i-2] + smp[i-3];
        default: p = 4 * smp[i-1] - 6 * smp[i-2] + 4 * smp[i-3] - smp[i-4];
      endcase
      r = smp[i] - p;
      u = (r >= 0) ? 2 * r : -2 * r - 1;
      q = u >> k;
      for (int z = 0; z < q; z++) exp_bits.push_back(1'b0);
      exp_bits.push_back(1'b1);
      put_bits(u, k);
    end
    while (exp_bits.size() % 16 != 0) exp_bits.push_back(1'b0);
    for (int i = 0; i < exp_bits.size(); i += 16) begin
      for (int j = 0; j < 16; j++) w[15-j] = exp_bits[i+j];
      exp_words.push_back(w);
    end
  endfunction

  function automatic int take(input int n);
    int v;
    v = 0;
    for (int j = 0; j < n; j++) begin
      v = v << 1;
      if (dpos < dbits.size()) v = v | int'(dbits[dpos]);
      dpos++;
    end
    return v;
  endfunction

  // Independent decoder: parses the captured RAM image back into samples.
  function automatic void model_decode(input int bs);
    int hdr, order, k, q, u, r, p, v;
    logic [15:0] w;
    dec.delete();
    dbits.delete();
    dpos = 0;
    foreach (got_words[i]) begin
      w = got_words[i];
      for (int j = 15; j >= 0; j--) dbits.push_back(w[j]);
    end
    hdr   = take(8);
    order = (hdr >> 1) & 7;
    for (int i = 0; i < order; i++) begin
      v = take(16);
      if (v >= 32768) v -= 65536;
      dec.push_back(v);
    end
    v = take(6);
    k = take(4);
    for (int i = order; i < bs && dpos < dbits.size(); i++) begin
      q = 0;
      while (dpos < dbits.size() && dbits[dpos] == 1'b0) begin
        q++;
        dpos++;
      end
      dpos++;
      u = (q << k) | take(k);
      r = (u & 1) ? -((u >> 1) + 1) : (u >> 1);
      case (order)
        0:       p = 0;
        1:       p = dec[i-1];
        2:       p = 2 * dec[i-1] - dec[i-2];
        3:       p = 3 * dec[i-1] - 3 * dec[i-2] + dec[i-3];
        default: p = 4 * dec[i-1] - 6 * dec[i-2] + 4 * dec[i-3] - dec[i-4];
      endcase
      dec.push_back(r + p);
    end
  endfunction

  // Drives one frame from smp[] and compares the captured words against the reference encoder.
  task automatic run_frame(input int order, input int k, input int bs, input bit noise,
                           input string tag);
    int waits;
    int s;
    got_words.delete();
    got_addrs.delete();
    done_cnt = 0;
    @(negedge iClock);
    iOrder     = order[2:0];
    iRiceParam = k[3:0];
    iBlockSize = bs[15:0];
    iEnable    = 1'b1;
    @(negedge iClock);
    iEnable = 1'b0;
    for (int i = 0; i < bs; i++) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        iSampleValid = 1'b0;
        iSample      = 16'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge iClock);
      end
      s            = smp[i];
      iSample      = s[15:0];
      iSampleValid = 1'b1;
      if (noise) begin
        iEnable    = 1'($urandom_range(0, 1));
        iOrder     = 3'($urandom);
        iRiceParam = 4'($urandom);
        iBlockSize = 16'($urandom);
      end
      waits = 0;
      while (!oReady && waits < 400) begin
        @(negedge iClock);
        waits++;
      end
      checks++;
      if (!oReady) begin
        errors++;
        $display("FAIL %s ready_timeout sample %0d: got oReady=0 want 1", tag, i);
        iSampleValid = 1'b0;
        iEnable      = 1'b0;
        return;
      end
      @(negedge iClock);
    end
    iSampleValid = 1'b0;
    iEnable      = 1'b0;
    waits = 0;
    while (done_cnt == 0 && waits < 1000) begin
      @(negedge iClock);
      waits++;
    end
    repeat (3) @(negedge iClock);
    model_encode(order, k, bs);
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
    end
    checks++;
    if (got_words.size() !== exp_words.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d want %0d", tag, got_words.size(), exp_words.size());
    end
`ifdef ENC_WORD_COUNT_EN
    checks++;
    if (oWordCount !== 16'(exp_words.size())) begin
      errors++;
      $display("FAIL %s oWordCount: got %0d want %0d", tag, oWordCount, exp_words.size());
    end
`endif
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
      checks++;
      if (got_words[i] !== exp_words[i]) begin
        errors++;
        $display("FAIL %s word[%0d]: got %h want %h", tag, i, got_words[i], exp_words[i]);
      end
      checks++;
      if (got_addrs[i] !== BASE + 16'(i)) begin
        errors++;
        $display("FAIL %s addr[%0d]: got %h want %h", tag, i, got_addrs[i], BASE + 16'(i));
      end
    end
  endtask

  task automatic test_reset;
    iReset = 1'b1; iEnable = 1'b0; iBlockSize = '0; iOrder = '0; iRiceParam = '0;
    iSample = '0; iSampleValid = 1'b0;
    repeat (2) @(negedge iClock);
    checks += 5;
    if (oReady !== 1'b0) begin errors++; $display("FAIL reset oReady: got %b want 0", oReady); end
    if (oWriteEnable !== 1'b0) begin
      errors++; $display("FAIL reset oWriteEnable: got %b want 0", oWriteEnable);
    end
    if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset oFrameDone: got %b want 0", oFrameDone); end
    if (oData !== 16'h0) begin errors++; $display("FAIL reset oData: got %h want 0000", oData); end
    if (oWriteAddr !== BASE) begin
      errors++; $display("FAIL reset oWriteAddr: got %h want %h", oWriteAddr, BASE);
    end
    iReset = 1'b0;
    repeat (2) @(negedge iClock);
    checks++;
    if (oReady !== 1'b0) begin errors++; $display("FAIL idle oReady: got %b want 0", oReady); end
  endtask

  task automatic test_zero_frame(input string tag);
    logic [15:0] want[$];
    want = '{16'h1000, 16'h3C00};
    smp = '{0, 0, 0, 0};
    run_frame(0, 0, 4, 1'b0, tag);
    for (int i = 0; i < want.size(); i++) begin
      checks++;
      if (i >= got_words.size() || got_words[i] !== want[i]) begin
        errors++;
        $display("FAIL %s const_word[%0d]: got %h want %h", tag, i,
                 (i < got_words.size()) ? got_words[i] : 16'hxxxx, want[i]);
      end
    end
  endtask

  task automatic test_order1;
    logic [15:0] want[$];
    want = '{16'h1200, 16'h6400, 16'hB700};
    smp = '{100, 101, 99};
    run_frame(1, 2, 3, 1'b0, "order1");
    for (int i = 0; i < want.size(); i++) begin
      checks++;
      if (i >= got_words.size() || got_words[i] !== want[i]) begin
        errors++;
        $display("FAIL order1 const_word[%0d]: got %h want %h", i,
                 (i < got_words.size()) ? got_words[i] : 16'hxxxx, want[i]);
      end
    end
  endtask

  task automatic test_negative_one;
    logic [15:0] want[$];
    want = '{16'h1000, 16'h1000};
    smp = '{-1};
    run_frame(0, 0, 1, 1'b0, "neg_one");
    for (int i = 0; i < want.size(); i++) begin
      checks++;
      if (i >= got_words.size() || got_words[i] !== want[i]) begin
        errors++;
        $display("FAIL neg_one const_word[%0d]: got %h want %h", i,
                 (i < got_words.size()) ? got_words[i] : 16'hxxxx, want[i]);
      end
    end
  endtask

  task automatic test_long_unary;
    smp = '{20};
    run_frame(0, 0, 1, 1'b0, "long_unary");
    smp = '{0, 1000, -1000, 3};
    run_frame(1, 1, 4, 1'b0, "long_unary_k1");
  endtask

  task automatic test_random_frames;
    int order, k, eff, bs, amp;
    for (int f = 0; f < 8; f++) begin
      order = $urandom_range(0, 7);
      k     = $urandom_range(0, 15);
      eff   = (order > 4) ? 4 : order;
      bs    = $urandom_range(eff + 1, 40);
      amp   = (k >= 14) ? 32767 : (1 << (k + 1));
      smp.delete();
      for (int i = 0; i < bs; i++) smp.push_back(int'($urandom_range(0, 2 * amp)) - amp);
      run_frame(order, k, bs, 1'b1, $sformatf("rand%0d", f));
    end
  endtask

  task automatic test_reset_mid_frame;
    int waits;
    smp.delete();
    @(negedge iClock);
    iOrder = 3'd0; iRiceParam = 4'd0; iBlockSize = 16'd8; iEnable = 1'b1;
    @(negedge iClock);
    iEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iSample = 16'($urandom_range(0, 7)); iSampleValid = 1'b1;
      waits = 0;
      while (!oReady && waits < 100) begin @(negedge iClock); waits++; end
      @(negedge iClock);
    end
    iReset = 1'b1;
    #1;
    checks += 5;
    if (oReady !== 1'b0) begin errors++; $display("FAIL midreset oReady: got %b want 0", oReady); end
    if (oWriteEnable !== 1'b0) begin
      errors++; $display("FAIL midreset oWriteEnable: got %b want 0", oWriteEnable);
    end
    if (oFrameDone !== 1'b0) begin
      errors++; $display("FAIL midreset oFrameDone: got %b want 0", oFrameDone);
    end
    if (oData !== 16'h0) begin errors++; $display("FAIL midreset oData: got %h want 0000", oData); end
    if (oWriteAddr !== BASE) begin
      errors++; $display("FAIL midreset oWriteAddr: got %h want %h", oWriteAddr, BASE);
    end
    iSampleValid = 1'b0;
    @(negedge iClock);
    iReset = 1'b0;
    test_zero_frame("after_reset");
  endtask

  task automatic test_full_scale;
    int s;
    smp.delete();
    for (int i = 0; i < 4096; i++) begin
      if (i < 2048) s = ((i * 37) % 65535) - 32767;
      else s = (i % 2 == 0) ? 32767 : -32767;
      smp.push_back(s);
    end
    run_frame(4, 14, 4096, 1'b0, "full_scale");
    model_decode(4096);
    checks++;
    if (dec.size() !== 4096) begin
      errors++;
      $display("FAIL full_scale decoded_count: got %0d want 4096", dec.size());
    end
    for (int i = 0; i < 4096 && i < dec.size(); i++) begin
      checks++;
      if (dec[i] !== smp[i]) begin
        errors++;
        $display("FAIL full_scale decoded[%0d]: got %0d want %0d", i, dec[i], smp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame("zero_frame");
    test_order1();
    test_negative_one();
    test_long_unary();
    test_random_frames();
    test_reset_mid_frame();
    test_full_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
